d_mem_banked: RTL

- Parametrised successor to the tile's dual-port data memory.
- Generalises port count, data width, depth and bank count, with word-interleaved banking.
- Adds a per-port valid/ready request handshake, per-bank round-robin arbitration on bank conflicts, and a registered read response with a valid flag.
- Sits between the core/ring initiators and the tile data storage. Any initiator may stall when it loses arbitration.

---
 rtl/d_mem_banked.sv | 112 +++++++++++
 1 files changed

// File: rtl/d_mem_banked.sv
// Banked, word-interleaved data memory with per-bank round-robin arbitration.
// Each bank serves one request per cycle. Reads respond one cycle after
// acceptance through a registered, zero-when-idle data path.
//
// Handshake: a request on port p is transferred on a rising edge where
// req_valid[p] && req_ready[p]. While req_valid[p]=1 and req_ready[p]=0 the
// initiator holds every req_* field of port p stable. req_ready is a
// combinational function of req_valid, req_addr and the per-bank pointers.
module d_mem_banked #(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int NUM_BANKS   = 2,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                                 clock,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0]                 req_wr,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   req_be,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]                 rsp_valid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]     rsp_rdata
);

  localparam int BYTES     = DATA_W / 8;
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int ROWS      = DEPTH_WORDS / NUM_BANKS;
  localparam int ROW_W     = (ADDR_W - BANK_BITS > 0) ? (ADDR_W - BANK_BITS) : 1;

  // Low address bits select the bank so consecutive words land in different banks.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    if (NUM_BANKS == 1) return '0;
    return a[BANK_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return ROW_W'(a >> BANK_BITS);
  endfunction

  // k-th port in round-robin order starting at the bank's pointer.
  function automatic logic [PTR_W-1:0] cand(input logic [PTR_W-1:0] ptr, input int k);
    return PTR_W'((int'(ptr) + k) % NUM_PORTS);
  endfunction

  logic [DATA_W-1:0]    mem [NUM_BANKS][ROWS];
  logic [PTR_W-1:0]     rr_ptr [NUM_BANKS];
  logic [PTR_W-1:0]     win [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_busy;
  logic [NUM_PORTS-1:0] is_read;

  // Per-bank arbitration: first requesting port at or after rr_ptr wins.
  always_comb begin
    req_ready = '0;
    bank_busy = '0;
    for (int b = 0; b < NUM_BANKS; b++) win[b] = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!bank_busy[b] && req_valid[cand(rr_ptr[b], k)] &&
            bank_of(req_addr[cand(rr_ptr[b], k)]) == BANK_W'(b)) begin
          bank_busy[b]                = 1'b1;
          win[b]                      = cand(rr_ptr[b], k);
          req_ready[cand(rr_ptr[b], k)] = 1'b1;
        end
      end
    end
  end

  assign is_read = req_ready & ~req_wr;

  // Pointer moves past the winner on a grant; idle banks keep their pointer.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_busy[b]) rr_ptr[b] <= PTR_W'((int'(win[b]) + 1) % NUM_PORTS);
      end
    end
  end

  // Storage: byte-masked writes from granted write requests. Contents are
  // never reset; initiators are expected to stay idle while rst is high.
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (req_ready[p] && req_wr[p]) begin
        for (int i = 0; i < BYTES; i++) begin
          if (req_be[p][i])
            mem[bank_of(req_addr[p])][row_of(req_addr[p])][i*8 +: 8] <= req_wdata[p][i*8 +: 8];
        end
      end
    end
  end

  // Read response register: one-cycle latency, data forced to zero when idle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_valid[p] <= is_read[p];
        rsp_rdata[p] <= is_read[p] ? mem[bank_of(req_addr[p])][row_of(req_addr[p])] : '0;
      end
    end
  end

endmodule
